// File: rtl/myfilter_pkg.sv
// Shared types and constants for the 5-tap FIR filter datapath.
//
// dp_cmd_t is the per-clock micro-operation issued by the datapath controller
// to dmem, cmem, ALU and accumulator. dpc_fsm_t is the controller state.

package myfilter_pkg;

    localparam int unsigned NTAPS    = 5;
    localparam int unsigned ADDRBITS = $clog2(NTAPS);

    // ALU operations:
    //   ALU_MU   - multiply only (first tap)
    //   ALU_ADMU - multiply and add to the accumulator
    //   ALU_SATA - saturate the accumulator to the output width
    typedef enum logic [1:0] {
        ALU_NOP  = 2'd0,
        ALU_MU   = 2'd1,
        ALU_ADMU = 2'd2,
        ALU_SATA = 2'd3
    } alu_op_t;

    // Field order is the bit order on dp_cmd_out, from MSB down to LSB.
    typedef struct packed {
        logic                dmem_shift;  // capture new sample, shift history
        logic                dmem_clr;    // clear sample history
        logic [ADDRBITS-1:0] cmem_addr;   // coefficient address
        logic [ADDRBITS-1:0] dmem_addr;   // sample history address
        alu_op_t             alu_op;
        logic                acc_load;    // accumulator captures ALU result
        logic                extvalid;    // filter output valid
    } dp_cmd_t;

    localparam int unsigned CMDBITS = $bits(dp_cmd_t);

    // Build a command; both memories always use the same tap index.
    function automatic dp_cmd_t mk_cmd(logic shift, logic clr, int unsigned tap,
                                       alu_op_t alu, logic acc, logic xv);
        dp_cmd_t c;
        c.dmem_shift = shift;
        c.dmem_clr   = clr;
        c.cmem_addr  = ADDRBITS'(tap);
        c.dmem_addr  = ADDRBITS'(tap);
        c.alu_op     = alu;
        c.acc_load   = acc;
        c.extvalid   = xv;
        return c;
    endfunction

    localparam dp_cmd_t CMD_NOP    = mk_cmd(1'b0, 1'b0, 0, ALU_NOP,  1'b0, 1'b0);
    localparam dp_cmd_t CMD_SHIFT  = mk_cmd(1'b1, 1'b0, 0, ALU_NOP,  1'b0, 1'b0);
    localparam dp_cmd_t CMD_CLR    = mk_cmd(1'b0, 1'b1, 0, ALU_NOP,  1'b0, 1'b0);
    localparam dp_cmd_t CMD_TAP0F  = mk_cmd(1'b0, 1'b0, 0, ALU_MU,   1'b1, 1'b0);
    localparam dp_cmd_t CMD_TAP1   = mk_cmd(1'b0, 1'b0, 1, ALU_ADMU, 1'b1, 1'b0);
    localparam dp_cmd_t CMD_TAP2   = mk_cmd(1'b0, 1'b0, 2, ALU_ADMU, 1'b1, 1'b0);
    localparam dp_cmd_t CMD_TAP3   = mk_cmd(1'b0, 1'b0, 3, ALU_ADMU, 1'b1, 1'b0);
    localparam dp_cmd_t CMD_TAP4   = mk_cmd(1'b0, 1'b0, 4, ALU_ADMU, 1'b1, 1'b0);
    localparam dp_cmd_t CMD_SAT_SH = mk_cmd(1'b0, 1'b0, 0, ALU_SATA, 1'b1, 1'b0);
    localparam dp_cmd_t CMD_EXTOUT = mk_cmd(1'b0, 1'b0, 0, ALU_NOP,  1'b0, 1'b1);

    typedef enum logic [3:0] {
        STOPPED,
        PROGRAM,
        EXTIN,
        TAP0,
        TAP1,
        TAP2,
        TAP3,
        TAP4,
        SAT,
        EXTOUT
    } dpc_fsm_t;

endpackage

// File: rtl/myfilter_dpc.sv
// myfilter_dpc - datapath controller for the 5-tap FIR filter.
//
// Sequences dmem, cmem, ALU and accumulator one micro-operation per clock,
// hands memory ownership to the I2C configuration path while a frame is in
// progress, and keeps a sticky flag for input samples that arrived while the
// datapath could not accept them.
//
// Ports:
//   clk               in   system clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   enable_in         in   1 = run, 0 = stop after the current sample
//   program_in        in   I2C frame in progress, requests memory ownership
//   clear_in          in   pulse: clear the dmem sample history
//   extvalid_in       in   pulse: new input sample on the dmem data input
//   dp_cmd_out        out  dp_cmd_t command vector to the datapath
//   prog_grant_out    out  1 = memories owned by I2C, ignore dp_cmd_out
//   busy_out          out  1 while a sample is being computed
//   sample_missed_out out  sticky: an extvalid_in pulse was dropped

module myfilter_dpc
    import myfilter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_in,
    input  logic               program_in,
    input  logic               clear_in,
    input  logic               extvalid_in,
    output logic [CMDBITS-1:0] dp_cmd_out,
    output logic               prog_grant_out,
    output logic               busy_out,
    output logic               sample_missed_out
);

    dpc_fsm_t state_q, state_d;
    dp_cmd_t  cmd_q, cmd_d;
    logic     prog_grant_q, prog_grant_d;
    logic     busy_q, busy_d;
    logic     missed_q, missed_d;
    logic     clear_pending_q, clear_pending_d;

    // Mealy decode in STOPPED/EXTIN, overlaid on the registered command.
    logic     do_clr;
    logic     do_shift;

    // State-only part of the command vector.
    function automatic dp_cmd_t state_cmd(dpc_fsm_t s);
        dp_cmd_t c;
        case (s)
            TAP0:    c = CMD_TAP0F;
            TAP1:    c = CMD_TAP1;
            TAP2:    c = CMD_TAP2;
            TAP3:    c = CMD_TAP3;
            TAP4:    c = CMD_TAP4;
            SAT:     c = CMD_SAT_SH;
            EXTOUT:  c = CMD_EXTOUT;
            default: c = CMD_NOP;
        endcase
        return c;
    endfunction

    function automatic logic state_busy(dpc_fsm_t s);
        logic b;
        case (s)
            TAP0, TAP1, TAP2, TAP3, TAP4, SAT, EXTOUT: b = 1'b1;
            default:                                   b = 1'b0;
        endcase
        return b;
    endfunction

    always_comb begin
        state_d         = state_q;
        do_clr          = 1'b0;
        do_shift        = 1'b0;
        // Outside an accepting EXTIN cycle a clear is deferred and a sample
        // is dropped; the cases below override these defaults.
        clear_pending_d = clear_pending_q | clear_in;
        missed_d        = missed_q | extvalid_in;

        case (state_q)
            STOPPED: begin
                // The datapath is idle, so a clear can run right away.
                do_clr = clear_in;
                if (program_in) begin
                    state_d = PROGRAM;
                end else if (enable_in) begin
                    state_d = EXTIN;
                end
            end

            PROGRAM: begin
                if (!program_in) begin
                    state_d = enable_in ? EXTIN : STOPPED;
                end
            end

            EXTIN: begin
                if (program_in) begin
                    state_d = PROGRAM;
                end else if (!enable_in) begin
                    state_d = STOPPED;
                end else if (clear_in || clear_pending_q) begin
                    do_clr = 1'b1;
                end else if (extvalid_in) begin
                    do_shift = 1'b1;
                    missed_d = missed_q;
                    state_d  = TAP0;
                end
            end

            TAP0: state_d = TAP1;
            TAP1: state_d = TAP2;
            TAP2: state_d = TAP3;
            TAP3: state_d = TAP4;
            TAP4: state_d = SAT;
            SAT:  state_d = EXTOUT;

            EXTOUT: begin
                if (program_in) begin
                    state_d = PROGRAM;
                end else if (!enable_in) begin
                    state_d = STOPPED;
                end else begin
                    state_d = EXTIN;
                end
            end

            default: state_d = STOPPED;
        endcase

        // An executed clear wipes the history, so any pending request and
        // the dropped-sample record go with it; a coincident sample is lost
        // silently.
        if (do_clr) begin
            clear_pending_d = 1'b0;
            missed_d        = 1'b0;
        end

        cmd_d        = state_cmd(state_d);
        prog_grant_d = (state_d == PROGRAM);
        busy_d       = state_busy(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= STOPPED;
            cmd_q           <= CMD_NOP;
            prog_grant_q    <= 1'b0;
            busy_q          <= 1'b0;
            missed_q        <= 1'b0;
            clear_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cmd_q           <= cmd_d;
            prog_grant_q    <= prog_grant_d;
            busy_q          <= busy_d;
            missed_q        <= missed_d;
            clear_pending_q <= clear_pending_d;
        end
    end

    // The Mealy terms are gated by rst_n so a clear_in or extvalid_in held
    // during reset cannot leak a command onto the bus. cmd_q is CMD_NOP in
    // both states where the Mealy terms can fire.
    always_comb begin
        dp_cmd_out = cmd_q;
        if (rst_n && do_clr) begin
            dp_cmd_out = CMD_CLR;
        end else if (rst_n && do_shift) begin
            dp_cmd_out = CMD_SHIFT;
        end
    end

    assign prog_grant_out    = prog_grant_q;
    assign busy_out          = busy_q;
    assign sample_missed_out = missed_q;

endmodule

// File: tb/tb_myfilter_dpc.sv
// Bench for myfilter_dpc: a per-cycle vector table for the control sequences,
// an extvalid scoreboard for sample streams, and a mid-sample reset sequence.

module tb_myfilter_dpc;

    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable_in, program_in, clear_in, extvalid_in;
    logic [CW-1:0] dp_cmd_out;
    logic          prog_grant_out, busy_out, sample_missed_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    myfilter_dpc dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable_in         (enable_in),
        .program_in        (program_in),
        .clear_in          (clear_in),
        .extvalid_in       (extvalid_in),
        .dp_cmd_out        (dp_cmd_out),
        .prog_grant_out    (prog_grant_out),
        .busy_out          (busy_out),
        .sample_missed_out (sample_missed_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected command words: {shift, clr, cmem_addr, dmem_addr, alu, acc_load, extvalid}
    function automatic logic [CW-1:0] mk(logic sh, logic cl, logic [2:0] a, logic [1:0] alu,
                                          logic acc, logic xv);
        return {sh, cl, a, a, alu, acc, xv};
    endfunction

    logic [CW-1:0] c_nop, c_shift, c_clr, c_sat, c_out;
    logic [CW-1:0] c_tap [5];

    typedef struct {
        logic          en, prog, clr, ext;
        logic [CW-1:0] cmd;
        logic          grant, busy, missed;
    } vec_t;
    vec_t vecs[$];

    function automatic void row(logic en, logic prog, logic clr, logic ext, logic [CW-1:0] cmd,
                                logic grant, logic busy, logic missed);
        vec_t v;
        v.en = en; v.prog = prog; v.clr = clr; v.ext = ext;
        v.cmd = cmd; v.grant = grant; v.busy = busy; v.missed = missed;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic en, input logic pr, input logic cl, input logic ex);
        enable_in = en; program_in = pr; clear_in = cl; extvalid_in = ex;
    endtask

    // Finish the current cycle: sample point already passed, move to posedge + 1.
    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected cycle of each filter-output pulse.
    int exp_q[$];
    bit sb_on = 1'b0;
    int xv_seen = 0;

    always @(negedge clk) begin
        if (sb_on && rst_n && dp_cmd_out[0]) begin
            int e;
            xv_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extvalid: pulse at cycle %0d, expected no pulse", cyc);
            end else begin
                e = exp_q.pop_front();
                check("sb_extvalid_cycle", cyc, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        int xv_base;
        int last_acc;
        int nacc;

        c_nop   = mk(0, 0, 3'd0, 2'd0, 0, 0);
        c_shift = mk(1, 0, 3'd0, 2'd0, 0, 0);
        c_clr   = mk(0, 1, 3'd0, 2'd0, 0, 0);
        c_tap[0] = mk(0, 0, 3'd0, 2'd1, 1, 0);
        for (int i = 1; i < 5; i++) c_tap[i] = mk(0, 0, 3'(i), 2'd2, 1, 0);
        c_sat   = mk(0, 0, 3'd0, 2'd3, 1, 0);
        c_out   = mk(0, 0, 3'd0, 2'd0, 0, 1);

        //   en prog clr ext  cmd       grant busy missed
        row(1, 0, 0, 0, c_nop,    0, 0, 0);  // 0  STOPPED -> EXTIN
        row(1, 0, 0, 1, c_shift,  0, 0, 0);  // 1  sample accepted
        row(1, 0, 0, 0, c_tap[0], 0, 1, 0);  // 2
        row(1, 0, 0, 0, c_tap[1], 0, 1, 0);  // 3
        row(1, 0, 0, 0, c_tap[2], 0, 1, 0);  // 4
        row(1, 0, 0, 0, c_tap[3], 0, 1, 0);  // 5
        row(1, 0, 0, 0, c_tap[4], 0, 1, 0);  // 6
        row(1, 0, 0, 0, c_sat,    0, 1, 0);  // 7
        row(1, 0, 0, 0, c_out,    0, 1, 0);  // 8  output 7 cycles after SHIFT
        row(1, 0, 0, 1, c_shift,  0, 0, 0);  // 9  k+8 accepted
        row(1, 0, 0, 0, c_tap[0], 0, 1, 0);  // 10
        row(1, 0, 0, 0, c_tap[1], 0, 1, 0);  // 11
        row(1, 1, 0, 0, c_tap[2], 0, 1, 0);  // 12 program raised mid-sample
        row(1, 1, 0, 0, c_tap[3], 0, 1, 0);  // 13
        row(1, 1, 0, 0, c_tap[4], 0, 1, 0);  // 14
        row(1, 1, 0, 0, c_sat,    0, 1, 0);  // 15
        row(1, 1, 0, 0, c_out,    0, 1, 0);  // 16 -> PROGRAM
        row(1, 1, 0, 1, c_nop,    1, 0, 0);  // 17 granted; sample dropped
        row(1, 0, 0, 0, c_nop,    1, 0, 1);  // 18 program released
        row(1, 0, 0, 1, c_shift,  0, 0, 1);  // 19 back in EXTIN
        row(1, 0, 0, 0, c_tap[0], 0, 1, 1);  // 20
        row(1, 0, 0, 0, c_tap[1], 0, 1, 1);  // 21
        row(1, 0, 0, 0, c_tap[2], 0, 1, 1);  // 22
        row(1, 0, 1, 0, c_tap[3], 0, 1, 1);  // 23 clear deferred
        row(1, 0, 0, 0, c_tap[4], 0, 1, 1);  // 24
        row(1, 0, 0, 0, c_sat,    0, 1, 1);  // 25
        row(1, 0, 0, 0, c_out,    0, 1, 1);  // 26
        row(1, 0, 0, 1, c_clr,    0, 0, 1);  // 27 pending clear wins over sample
        row(1, 0, 1, 1, c_clr,    0, 0, 0);  // 28 clear + sample: no shift, no flag
        row(1, 0, 0, 1, c_shift,  0, 0, 0);  // 29 pending gone, sample accepted
        row(1, 0, 0, 0, c_tap[0], 0, 1, 0);  // 30
        row(0, 0, 0, 0, c_tap[1], 0, 1, 0);  // 31 enable dropped mid-sample
        row(0, 0, 0, 0, c_tap[2], 0, 1, 0);  // 32
        row(0, 0, 0, 0, c_tap[3], 0, 1, 0);  // 33
        row(0, 0, 0, 0, c_tap[4], 0, 1, 0);  // 34
        row(0, 0, 0, 0, c_sat,    0, 1, 0);  // 35
        row(0, 0, 0, 0, c_out,    0, 1, 0);  // 36 -> STOPPED
        row(0, 0, 0, 1, c_nop,    0, 0, 0);  // 37 sample while stopped
        row(0, 0, 0, 0, c_nop,    0, 0, 1);  // 38
        row(0, 0, 1, 0, c_clr,    0, 0, 1);  // 39 clear runs at once in STOPPED
        row(0, 0, 0, 0, c_nop,    0, 0, 0);  // 40
        row(0, 1, 0, 0, c_nop,    0, 0, 0);  // 41 STOPPED -> PROGRAM
        row(0, 0, 0, 0, c_nop,    1, 0, 0);  // 42 grant one cycle later
        row(0, 0, 0, 0, c_nop,    0, 0, 0);  // 43 back to STOPPED

        // Reset with clear/extvalid held high: nothing may leak onto the bus.
        drive(1, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_cmd", dp_cmd_out, c_nop);
            check("reset_grant", prog_grant_out, 0);
            check("reset_busy", busy_out, 0);
            check("reset_missed", sample_missed_out, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].prog, vecs[i].clr, vecs[i].ext);
            @(negedge clk);
            check($sformatf("row%0d_cmd", i), dp_cmd_out, vecs[i].cmd);
            check($sformatf("row%0d_grant", i), prog_grant_out, vecs[i].grant);
            check($sformatf("row%0d_busy", i), busy_out, vecs[i].busy);
            check($sformatf("row%0d_missed", i), sample_missed_out, vecs[i].missed);
            @(posedge clk);
            #1;
        end

        // Ten samples, one every 8 clocks: all accepted.
        drive(1, 0, 0, 0);
        step();
        sb_on = 1'b1;
        xv_base = xv_seen;
        for (int s = 0; s < 10; s++) begin
            for (int j = 0; j < 8; j++) begin
                drive(1, 0, 0, j == 0);
                if (j == 0) exp_q.push_back(cyc + 7);
                step();
            end
        end
        drive(1, 0, 0, 0);
        for (int t = 0; t < 16 && exp_q.size() != 0; t++) step();
        check("b2b8_drained", exp_q.size(), 0);
        check("b2b8_pulses", xv_seen - xv_base, 10);
        check("b2b8_missed", sample_missed_out, 0);

        // Ten samples, one every 7 clocks: every other one dropped.
        xv_base = xv_seen;
        last_acc = cyc - 100;
        nacc = 0;
        for (int s = 0; s < 10; s++) begin
            for (int j = 0; j < 7; j++) begin
                drive(1, 0, 0, j == 0);
                if (j == 0 && cyc - last_acc >= 8) begin
                    exp_q.push_back(cyc + 7);
                    last_acc = cyc;
                    nacc++;
                end
                step();
            end
        end
        drive(1, 0, 0, 0);
        for (int t = 0; t < 16 && exp_q.size() != 0; t++) step();
        check("b2b7_drained", exp_q.size(), 0);
        check("b2b7_pulses", xv_seen - xv_base, 5);
        check("b2b7_accepted", nacc, 5);
        check("b2b7_missed", sample_missed_out, 1);
        sb_on = 1'b0;

        // Reset asserted during SAT.
        drive(1, 0, 0, 1);
        @(negedge clk);
        check("rst_seq_shift", dp_cmd_out, c_shift);
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        @(negedge clk);
        check("rst_seq_sat", dp_cmd_out, c_sat);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_cmd", dp_cmd_out, c_nop);
        check("midrst_grant", prog_grant_out, 0);
        check("midrst_busy", busy_out, 0);
        check("midrst_missed", sample_missed_out, 0);
        drive(0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 1);
        @(negedge clk);
        check("postrst_cmd", dp_cmd_out, c_nop);
        check("postrst_busy", busy_out, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("postrst_missed", sample_missed_out, 1);
        check("postrst_busy2", busy_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
